// File: rtl/reg_file.sv
// Integer register file for the ID stage: two combinational read ports and one
// synchronous write port. x0 reads as zero, and reads see a same-cycle write first.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] ADDRW,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [ADDR_WIDTH-1:0] ADDR2,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_live;

  assign wr_live = !RESET && WRITE && (ADDRW != '0);

  // x0 is a constant, so there is no storage behind it.
  assign regs[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    always_ff @(posedge CLK) begin
      if (RESET)
        regs[r] <= '0;
      else if (WRITE && ADDRW == ADDR_WIDTH'(r))
        regs[r] <= IN;
    end
  end

  // Bypass is write-first; the x0 check sits ahead of it so x0 never forwards.
  always_comb begin
    OUT1 = regs[ADDR1];
    if (ADDR1 == '0)
      OUT1 = '0;
    else if (wr_live && ADDRW == ADDR1)
      OUT1 = IN;
  end

  always_comb begin
    OUT2 = regs[ADDR2];
    if (ADDR2 == '0)
      OUT2 = '0;
    else if (wr_live && ADDRW == ADDR2)
      OUT2 = IN;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: a vector table applied one per cycle with pre-edge
// checks, then a fill-and-sweep sequence over every register.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK;
  logic          RESET;
  logic [DW-1:0] IN;
  logic [AW-1:0] ADDRW;
  logic          WRITE;
  logic [AW-1:0] ADDR1;
  logic [AW-1:0] ADDR2;
  logic [DW-1:0] OUT1;
  logic [DW-1:0] OUT2;

  int total = 0;
  int bad   = 0;

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .ADDRW(ADDRW), .WRITE(WRITE),
    .ADDR1(ADDR1), .ADDR2(ADDR2), .OUT1(OUT1), .OUT2(OUT2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          rst;
    logic          wr;
    logic [AW-1:0] aw;
    logic [DW-1:0] din;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          chk;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic wr, input logic [AW-1:0] aw,
                       input logic [DW-1:0] din, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    @(negedge CLK);
    RESET = rst; WRITE = wr; ADDRW = aw; IN = din; ADDR1 = a1; ADDR2 = a2;
    #1;
  endtask

  initial begin
    RESET = 1'b0; WRITE = 1'b0; ADDRW = '0; IN = '0; ADDR1 = '0; ADDR2 = '0;

    //          rst   wr    aw  din           a1  a2  chk   e1            e2
    vecs[0]  = '{1'b1, 1'b1, 3,  32'd7,        3,  0,  1'b0, 32'd0,        32'd0};
    vecs[1]  = '{1'b0, 1'b0, 3,  32'd7,        3,  0,  1'b1, 32'd0,        32'd0};
    vecs[2]  = '{1'b0, 1'b0, 0,  32'd0,        0,  1,  1'b1, 32'd0,        32'd0};
    vecs[3]  = '{1'b0, 1'b1, 5,  32'd42,       5,  10, 1'b1, 32'd42,       32'd0};
    vecs[4]  = '{1'b0, 1'b1, 10, 32'd99,       5,  10, 1'b1, 32'd42,       32'd99};
    vecs[5]  = '{1'b0, 1'b0, 10, 32'd99,       5,  10, 1'b1, 32'd42,       32'd99};
    vecs[6]  = '{1'b0, 1'b0, 0,  32'd0,        0,  1,  1'b1, 32'd0,        32'd0};
    vecs[7]  = '{1'b0, 1'b1, 0,  32'hDEADBEEF, 0,  0,  1'b1, 32'd0,        32'd0};
    vecs[8]  = '{1'b0, 1'b0, 0,  32'hDEADBEEF, 0,  5,  1'b1, 32'd0,        32'd42};
    vecs[9]  = '{1'b0, 1'b1, 7,  32'h12345678, 7,  7,  1'b1, 32'h12345678, 32'h12345678};
    vecs[10] = '{1'b0, 1'b0, 7,  32'd0,        7,  7,  1'b1, 32'h12345678, 32'h12345678};
    vecs[11] = '{1'b0, 1'b0, 5,  32'd55,       5,  7,  1'b1, 32'd42,       32'h12345678};
    vecs[12] = '{1'b0, 1'b0, 5,  32'd55,       5,  7,  1'b1, 32'd42,       32'h12345678};
    vecs[13] = '{1'b0, 1'b0, 5,  32'd55,       5,  7,  1'b1, 32'd42,       32'h12345678};
    // Reset cycle with a write: no bypass, storage still shows the old values.
    vecs[14] = '{1'b1, 1'b1, 5,  32'd77,       5,  7,  1'b1, 32'd42,       32'h12345678};
    vecs[15] = '{1'b0, 1'b0, 5,  32'd77,       5,  7,  1'b1, 32'd0,        32'd0};
    vecs[16] = '{1'b0, 1'b0, 0,  32'd0,        10, 3,  1'b1, 32'd0,        32'd0};

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].aw, vecs[i].din, vecs[i].a1, vecs[i].a2);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d.out1", i), OUT1, vecs[i].e1);
        check($sformatf("vec%0d.out2", i), OUT2, vecs[i].e2);
      end
    end

    // Fill every register with a distinct value; port 1 watches the previous
    // register (storage) and port 2 the one being written (bypass).
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, 1'b1, AW'(r), 32'hA5000000 + DW'(r) * 32'h00010101, AW'(r - 1), AW'(r));
      check($sformatf("fill_bypass x%0d", r), OUT2, 32'hA5000000 + DW'(r) * 32'h00010101);
      if (r > 1)
        check($sformatf("fill_prev x%0d", r - 1), OUT1, 32'hA5000000 + DW'(r - 1) * 32'h00010101);
    end

    // Write to a different address must not leak into either read port.
    drive(1'b0, 1'b1, 5'd3, 32'hFFFF0000, 5'd4, 5'd0);
    check("nobypass_other x4", OUT1, 32'hA5000000 + 32'd4 * 32'h00010101);
    check("nobypass_x0", OUT2, 32'd0);

    // Address-only changes with no clock edge: reads are combinational.
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    check("x3_after_overwrite p1", OUT1, 32'hFFFF0000);
    check("x3_after_overwrite p2", OUT2, 32'hFFFF0000);
    for (int r = 0; r < 32; r++) begin
      logic [DW-1:0] exp;
      ADDR1 = AW'(r);
      ADDR2 = AW'(31 - r);
      #1;
      exp = (r == 0) ? 32'd0 : (r == 3) ? 32'hFFFF0000 : 32'hA5000000 + DW'(r) * 32'h00010101;
      check($sformatf("sweep p1 x%0d", r), OUT1, exp);
      exp = (r == 31) ? 32'd0 : (r == 28) ? 32'hFFFF0000
            : 32'hA5000000 + DW'(31 - r) * 32'h00010101;
      check($sformatf("sweep p2 x%0d", 31 - r), OUT2, exp);
    end

    // Final reset clears everything that was filled.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd17);
    check("final_reset x31", OUT1, 32'd0);
    check("final_reset x17", OUT2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- General-purpose integer register file for the RV32IM pipelined processor, located in the ID stage.
- Provides two combinational read ports (rs1, rs2) and one synchronous write port (rd, driven from writeback).
- Register x0 is hardwired to zero.
- Internal write-to-read bypass, so the ID stage sees a value written in the same cycle.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset; clears all registers
- IN  input  DATA_WIDTH  write data (from writeback)
- ADDRW  input  ADDR_WIDTH  write register index (rd)
- WRITE  input  1  write enable
- ADDR1  input  ADDR_WIDTH  read port 1 index (rs1)
- ADDR2  input  ADDR_WIDTH  read port 2 index (rs2)
- OUT1  output  DATA_WIDTH  read port 1 data
- OUT2  output  DATA_WIDTH  read port 2 data

Behaviour:
- One clock (CLK); reset RESET is synchronous and active-high; no other clock or async logic.
- Storage: NUM_REGS registers of DATA_WIDTH bits. Undefined (X) before the first reset.
- Reset: on a rising CLK edge with RESET=1, every register becomes 0.
  - Reset has priority over WRITE in that cycle; the write is dropped.
  - After reset, OUT1/OUT2 read 0 for any address.
- Write: on a rising CLK edge with RESET=0, WRITE=1 and ADDRW!=0, reg[ADDRW] <= IN.
  - Writes to ADDRW=0 are ignored; x0 always reads 0.
- Read timing: reads are combinational (zero latency).
  - OUT1 = reg[ADDR1] and OUT2 = reg[ADDR2], updating immediately on address or register change.
- x0 reads: ADDR1=0 gives OUT1=0 and ADDR2=0 gives OUT2=0, regardless of any bypass.
- Bypass: if RESET=0, WRITE=1, ADDRW!=0 and ADDRW==ADDRx, then OUTx = IN combinationally (write-first).
  - Applies independently to each port; both ports may bypass simultaneously.
  - No bypass while RESET=1.
- No WRITE: with WRITE=0, register contents hold indefinitely.
- Read-only addresses: read ports never modify state, including when both ports select the same address.
- Write latency: a value written at edge N is readable from storage immediately after edge N, and via bypass during the cycle before edge N.
- No handshake, no stall inputs, no error outputs.

Test Plan:
- Reset clear: hold RESET=1 for one edge with WRITE=1, ADDRW=3, IN=7 -> after the edge, reg x3 reads 0 and ADDR1=0/ADDR2=1 read OUT1=0, OUT2=0.
- Basic writes: write 42 to x5, then 99 to x10, on consecutive edges with WRITE=1; then set WRITE=0, ADDR1=5, ADDR2=10 -> OUT1=42, OUT2=99.
- Unwritten and x0: after the basic writes, ADDR1=0, ADDR2=1 -> OUT1=0, OUT2=0.
- x0 protection: WRITE=1, ADDRW=0, IN=0xDEADBEEF for one edge; ADDR1=0 -> OUT1=0 both before and after the edge.
- Bypass: WRITE=1, ADDRW=7, IN=0x12345678, ADDR1=ADDR2=7 before the edge -> OUT1=OUT2=0x12345678 combinationally; after the edge with WRITE=0 both still read 0x12345678.
- Hold and reset priority: WRITE=0, IN=55, ADDRW=5 over several edges -> x5 stays 42; then RESET=1 with WRITE=1 -> all registers read 0 after the edge.
